// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: read enable, byte address,
// and the word that comes back one cycle after the address was issued.
interface instr_fetch_stage_if;
  logic        en;
  logic [31:0] addr;
  logic [31:0] rdata;

  // Fetch stage drives the request and consumes the returned word.
  modport master (output en, output addr, input rdata);
  // Synchronous instruction memory answers the request.
  modport slave (input en, input addr, output rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the mini-MIPS core.
// Owns the program counter, drives the synchronous instruction memory and
// presents the fetched word to decode, with decode stall and branch/jump
// redirect support.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  instr_fetch_stage_if.master        imem,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [5:0]                 id_opcode,
  output logic [5:0]                 id_funct,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_pc_plus4,
  output logic [31:0]                fetch_count
);

  // BOOT: no fetch in flight yet, so the memory data is not meaningful.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        id_valid_d;
  logic [31:0] id_instr_d;
  logic [31:0] id_pc_d;
  logic [31:0] id_pc_plus4_d;
  logic [31:0] fetch_count_d;

  logic [31:0] fetch_pc_plus4;
  logic [31:0] redirect_aligned;

  // The target's byte offset is meaningless for word fetches.
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign fetch_pc_plus4   = fetch_pc_q + 32'd4;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Memory is read every cycle out of reset; reset gates it off immediately.
  assign imem.en = rst_n;

  // Decoder fields are plain wiring of the registered instruction.
  assign id_opcode = id_instr[31:26];
  assign id_funct  = id_instr[5:0];

  // Fetch address selection: redirect wins, then re-read on boot/stall.
  always_comb begin
    if (redirect) begin
      imem.addr = redirect_aligned;
    end else if (state_q == BOOT || stall) begin
      imem.addr = fetch_pc_q;
    end else begin
      imem.addr = fetch_pc_plus4;
    end
  end

  // Next-state and IF/ID update rules.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    id_valid_d    = id_valid;
    id_instr_d    = id_instr;
    id_pc_d       = id_pc;
    id_pc_plus4_d = id_pc_plus4;
    fetch_count_d = fetch_count;

    unique case (state_q)
      BOOT: begin
        fetch_pc_d = imem.addr;
        state_d    = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Squash the wrong-path word arriving this cycle.
          id_valid_d = 1'b0;
          id_instr_d = 32'h0;
          fetch_pc_d = redirect_aligned;
        end else if (stall) begin
          // Hold everything; the same address is being re-read.
        end else begin
          id_valid_d    = 1'b1;
          id_instr_d    = imem.rdata;
          id_pc_d       = fetch_pc_q;
          id_pc_plus4_d = fetch_pc_plus4;
          fetch_pc_d    = fetch_pc_plus4;
          fetch_count_d = fetch_count + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and IF/ID register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      id_valid    <= id_valid_d;
      id_instr    <= id_instr_d;
      id_pc       <= id_pc_d;
      id_pc_plus4 <= id_pc_plus4_d;
      fetch_count <= fetch_count_d;
    end
  end

endmodule
